// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Execute-stage ALU with registered outputs, a start/done
//               handshake, and iterative unsigned multiply / restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] c_F_AND   = 4'b0000;
    localparam logic [3:0] c_F_OR    = 4'b0001;
    localparam logic [3:0] c_F_ADD   = 4'b0010;
    localparam logic [3:0] c_F_SLTU  = 4'b0011;
    localparam logic [3:0] c_F_ANDN  = 4'b0100;
    localparam logic [3:0] c_F_ORN   = 4'b0101;
    localparam logic [3:0] c_F_SUB   = 4'b0110;
    localparam logic [3:0] c_F_SLT   = 4'b0111;
    localparam logic [3:0] c_F_MULTU = 4'b1000;
    localparam logic [3:0] c_F_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic               r_done;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_hi;
    logic               r_zero;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_alu_y;
    logic               w_slt;
    logic               w_sltu;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic               w_cnt_last;

    // Single-cycle operations
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

    always_comb begin
        w_alu_y = '0;
        case (f)
            c_F_AND:  w_alu_y = a & b;
            c_F_OR:   w_alu_y = a | b;
            c_F_ADD:  w_alu_y = a + b;
            c_F_SLTU: w_alu_y = {{(WIDTH-1){1'b0}}, w_sltu};
            c_F_ANDN: w_alu_y = a & ~b;
            c_F_ORN:  w_alu_y = a | ~b;
            c_F_SUB:  w_alu_y = a - b;
            c_F_SLT:  w_alu_y = {{(WIDTH-1){1'b0}}, w_slt};
            default:  w_alu_y = '0;
        endcase
    end

    // Shift-add step: the multiplier occupies acc_lo and is consumed LSB first
    // while product bits shift in from the top; {acc_hi,acc_lo} ends as a*b.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out at the top and quotient bits in at the bottom.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_div_hi    = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_div_ge};

    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_done   <= 1'b0;
            r_y      <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (f == c_F_MULTU || f == c_F_DIVU) begin
                            r_state  <= (f == c_F_MULTU) ? S_MUL : S_DIV;
                            r_opa    <= a;
                            r_opb    <= b;
                            r_acc_hi <= '0;
                            r_acc_lo <= a;
                            r_cnt    <= '0;
                        end else begin
                            r_y    <= w_alu_y;
                            r_hi   <= '0;
                            r_zero <= (w_alu_y == '0);
                            r_dbz  <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_mul_hi;
                    r_acc_lo <= w_mul_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_cnt_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_y     <= w_mul_lo;
                        r_hi    <= w_mul_hi;
                        r_zero  <= (w_mul_lo == '0);
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc_hi <= w_div_hi;
                    r_acc_lo <= w_div_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_cnt_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        // Divide by zero still runs the full latency for a fixed timing
                        if (r_opb == '0) begin
                            r_y    <= '1;
                            r_hi   <= r_opa;
                            r_zero <= 1'b0;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_y    <= w_div_lo;
                            r_hi   <= w_div_hi;
                            r_zero <= (w_div_lo == '0);
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign done        = r_done;
    assign y           = r_y;
    assign hi          = r_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Self-checking bench for alu_muldiv against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       f;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .f           (f),
        .ready       (ready),
        .done        (done),
        .y           (y),
        .hi          (hi),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the opcode definitions
    task automatic model(input logic [3:0] fi, input logic [31:0] ai, input logic [31:0] bi,
                         output logic [31:0] ey, output logic [31:0] eh,
                         output logic edz, output int lat);
        longint unsigned p;
        ey = 0; eh = 0; edz = 0; lat = 1;
        case (fi)
            4'd0: ey = ai & bi;
            4'd1: ey = ai | bi;
            4'd2: ey = ai + bi;
            4'd3: ey = (ai < bi) ? 1 : 0;
            4'd4: ey = ai & ~bi;
            4'd5: ey = ai | ~bi;
            4'd6: ey = ai - bi;
            4'd7: ey = ($signed(ai) < $signed(bi)) ? 1 : 0;
            4'd8: begin
                p  = longint'(ai) * longint'(bi);
                ey = p[31:0];
                eh = p[63:32];
                lat = WIDTH + 1;
            end
            4'd9: begin
                lat = WIDTH + 1;
                if (bi == 0) begin
                    ey = 32'hFFFF_FFFF; eh = ai; edz = 1;
                end else begin
                    ey = ai / bi; eh = ai % bi;
                end
            end
            default: ;
        endcase
    endtask

    // Launch one op, wait (bounded) for done, and check timing and results.
    task automatic run_op(input string tag, input logic [3:0] fi, input logic [31:0] ai,
                          input logic [31:0] bi, input bit toggle);
        logic [31:0] ey, eh;
        logic        edz;
        int          lat, n, busy;
        model(fi, ai, bi, ey, eh, edz, lat);
        @(negedge clk);
        start = 1; f = fi; a = ai; b = bi;
        @(negedge clk);
        start = 0;
        n = 1; busy = 0;
        while (done !== 1'b1 && n < 100) begin
            if (ready === 1'b0) busy++;
            if (toggle) begin
                start = 1'($urandom); f = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 0;
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_busy"}, 64'(busy), 64'(lat - 1));
        chk({tag, "_y"}, 64'(y), 64'(ey));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_zero"}, 64'(zero), 64'(ey == 0));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
        chk({tag, "_ready"}, 64'(ready), 64'(1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [3:0]  rf;
        logic [31:0] ra, rb;

        reset = 1; start = 0; a = 0; b = 0; f = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done",  64'(done), 64'(0));
        chk("rst_y",     64'(y), 64'(0));
        chk("rst_hi",    64'(hi), 64'(0));
        chk("rst_zero",  64'(zero), 64'(1));
        chk("rst_dbz",   64'(div_by_zero), 64'(0));
        reset = 0;

        run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 0);
        run_op("add_nz", 4'b0010, 32'd7, 32'd9, 0);

        // Back-to-back SLT then SLTU
        @(negedge clk);
        start = 1; f = 4'b0111; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        chk("b2b_done1", 64'(done), 64'(1));
        chk("b2b_slt",   64'(y), 64'(1));
        chk("b2b_rdy",   64'(ready), 64'(1));
        f = 4'b0011;
        @(negedge clk);
        start = 0;
        chk("b2b_done2", 64'(done), 64'(1));
        chk("b2b_sltu",  64'(y), 64'(0));

        run_op("mul_ff_2",  4'b1000, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("div_100_7", 4'b1001, 32'd100, 32'd7, 0);
        run_op("div_5_0",   4'b1001, 32'd5, 32'd0, 0);
        run_op("add_clr",   4'b0010, 32'd1, 32'd1, 0);
        run_op("mul_toggle", 4'b1000, 32'd3, 32'd4, 1);
        run_op("mul_max",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_small", 4'b1001, 32'd3, 32'hFFFF_FFFF, 0);

        // Reset mid-multiply
        @(negedge clk);
        start = 1; f = 4'b1000; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        chk("mr_busy", 64'(ready), 64'(0));
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mr_ready", 64'(ready), 64'(1));
        chk("mr_done",  64'(done), 64'(0));
        chk("mr_y",     64'(y), 64'(0));
        chk("mr_zero",  64'(zero), 64'(1));
        begin
            int dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
            end
            chk("mr_no_done", 64'(dn), 64'(0));
        end
        run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0);

        // Reset and start together: start dropped
        @(negedge clk);
        reset = 1; start = 1; f = 4'b0010; a = 32'd10; b = 32'd20;
        @(negedge clk);
        reset = 0; start = 0;
        chk("rs_done", 64'(done), 64'(0));
        chk("rs_y",    64'(y), 64'(0));
        @(negedge clk);
        chk("rs_done2", 64'(done), 64'(0));

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            rf = 4'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op("rand", rf, ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
